// File: rtl/systolic_drain.sv
// Bottom-edge collector for the systolic array: de-skews the staggered PE outputs into
// whole rows and queues them in a small FIFO drained over a valid/ready handshake.
module systolic_drain #(
  parameter int unsigned N        = 4,
  parameter int unsigned M        = 4,
  parameter int unsigned NUM_BITS = 8,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [N*NUM_BITS-1:0] col_i,
  output logic [N*NUM_BITS-1:0] row_o,
  output logic                  row_valid_o,
  input  logic                  row_ready_i,
  output logic                  busy_o,
  output logic                  overflow_o
);

  localparam int unsigned W     = N * NUM_BITS;
  localparam int unsigned FillW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RowW  = $clog2(M + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  localparam logic [FillW-1:0] FillLast = FillW'((N > 1) ? N - 2 : 0);
  localparam logic [RowW-1:0]  RowLast  = RowW'(M - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic [W-1:0] w_aligned;

  // Column c is delayed N-1-c cycles so every column of a row lines up with column N-1.
  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int Stages = int'(N) - 1 - c;
    if (Stages == 0) begin : g_comb
      assign w_aligned[c*NUM_BITS +: NUM_BITS] = col_i[c*NUM_BITS +: NUM_BITS];
    end else begin : g_dly
      logic [NUM_BITS-1:0] r_dly [Stages];
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int s = 0; s < Stages; s++) begin
            r_dly[s] <= '0;
          end
        end else begin
          r_dly[0] <= col_i[c*NUM_BITS +: NUM_BITS];
          for (int s = 1; s < Stages; s++) begin
            r_dly[s] <= r_dly[s-1];
          end
        end
      end
      assign w_aligned[c*NUM_BITS +: NUM_BITS] = r_dly[Stages-1];
    end
  end

  logic [1:0]       r_state, w_state_nxt;
  logic [FillW-1:0] r_fill_cnt, w_fill_nxt;
  logic [RowW-1:0]  r_row_cnt, w_row_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_row_nxt   = r_row_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_fill_nxt  = '0;
          w_row_nxt   = '0;
          w_state_nxt = (N == 1) ? ST_CAPTURE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (r_fill_cnt == FillLast) begin
          w_state_nxt = ST_CAPTURE;
          w_row_nxt   = '0;
        end else begin
          w_fill_nxt = r_fill_cnt + 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (r_row_cnt == RowLast) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_row_nxt = r_row_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_fill_cnt <= '0;
      r_row_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_row_cnt  <= w_row_nxt;
    end
  end

  logic [W-1:0]    r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_overflow;
  logic            w_push, w_pop, w_push_ok;

  assign w_push    = (r_state == ST_CAPTURE);
  assign w_pop     = (r_count != '0) && row_ready_i;
  // A full FIFO still takes the row when the head leaves in the same cycle.
  assign w_push_ok = w_push && ((r_count != CntFull) || w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CntW'(w_push_ok) - CntW'(w_pop);
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_aligned;
  end

  assign row_valid_o = (r_count != '0);
  assign row_o       = row_valid_o ? r_mem[r_rd_ptr] : '0;
  assign busy_o      = (r_state != ST_IDLE);
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: a DEPTH=4 instance for the main scenarios and a DEPTH=2
// instance fed the same stimulus for the overflow case.
module tb_systolic_drain;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [31:0]   col = '0;
  logic [31:0]   row_a, row_b;
  logic          val_a, val_b, busy_a, busy_b, ovf_a, ovf_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  systolic_drain #(.N(N), .M(M), .NUM_BITS(NB), .DEPTH(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .col_i(col), .row_o(row_a),
    .row_valid_o(val_a), .row_ready_i(ready), .busy_o(busy_a), .overflow_o(ovf_a)
  );

  systolic_drain #(.N(N), .M(M), .NUM_BITS(NB), .DEPTH(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .col_i(col), .row_o(row_b),
    .row_valid_o(val_b), .row_ready_i(ready), .busy_o(busy_b), .overflow_o(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] row_val(input int r);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*NB +: NB] = 8'(16 * r + c);
    return v;
  endfunction

  // Skewed arrival: column c of row r (numbered from roff) appears at cycle t0+1+r+c.
  function automatic logic [31:0] col_at(input int cyc, input int t0, input int roff);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < N; c++) begin
      int r;
      r = cyc - t0 - 1 - c;
      if (r >= 0 && r < M) v[c*NB +: NB] = 8'(16 * (r + roff) + c);
    end
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; leaves time just before the falling edge for sampling.
  task automatic drive(input logic st, input logic [31:0] c, input logic rdy);
    start = st;
    col   = c;
    ready = rdy;
    #3;
  endtask

  task automatic reset_dut();
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    col   = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic run_basic(input string nm, input bit extra_start);
    for (int k = 0; k <= 10; k++) begin
      logic ev;
      drive((k == 0) || (extra_start && k == 3), col_at(k, 0, 0), 1'b1);
      ev = (k >= 5 && k <= 8);
      check($sformatf("%s valid c%0d", nm, k), 32'(val_a), 32'(ev));
      check($sformatf("%s row c%0d", nm, k), row_a, ev ? row_val(k - 5) : 32'h0);
      check($sformatf("%s busy c%0d", nm, k), 32'(busy_a), 32'(k >= 1 && k <= 7));
      check($sformatf("%s ovf c%0d", nm, k), 32'(ovf_a), 32'h0);
      next_cycle();
    end
  endtask

  initial begin
    #1;
    reset_dut();

    // Basic pass
    run_basic("basic", 1'b0);

    // Backpressure on DEPTH=4 and overflow on DEPTH=2, same stimulus
    reset_dut();
    for (int k = 0; k <= 17; k++) begin
      logic [31:0] ea, eb;
      drive(k == 0, col_at(k, 0, 0), k >= 12);
      ea = (k < 5) ? 32'h0 : (k <= 11) ? row_val(0) : (k <= 15) ? row_val(k - 12) : 32'h0;
      eb = (k < 5) ? 32'h0 : (k <= 12) ? row_val(0) : (k == 13) ? row_val(1) : 32'h0;
      check($sformatf("bp valid c%0d", k), 32'(val_a), 32'(k >= 5 && k <= 15));
      check($sformatf("bp row c%0d", k), row_a, ea);
      check($sformatf("bp ovf c%0d", k), 32'(ovf_a), 32'h0);
      check($sformatf("ovf valid c%0d", k), 32'(val_b), 32'(k >= 5 && k <= 13));
      check($sformatf("ovf row c%0d", k), row_b, eb);
      check($sformatf("ovf flag c%0d", k), 32'(ovf_b), 32'(k >= 7));
      next_cycle();
    end

    // Start pulse while busy is ignored
    reset_dut();
    run_basic("rebusy", 1'b1);

    // Asynchronous reset mid-cycle 6
    reset_dut();
    for (int k = 0; k <= 6; k++) begin
      drive(k == 0, col_at(k, 0, 0), 1'b1);
      if (k < 6) next_cycle();
    end
    check("pre-rst valid", 32'(val_a), 32'h1);
    check("pre-rst row", row_a, row_val(1));
    #1 rst = 1'b1;
    #1;
    check("rst valid", 32'(val_a), 32'h0);
    check("rst busy", 32'(busy_a), 32'h0);
    check("rst row", row_a, 32'h0);
    check("rst ovf", 32'(ovf_a), 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'hdead_beef, 1'b1);
      check($sformatf("post-rst valid c%0d", k), 32'(val_a), 32'h0);
      check($sformatf("post-rst busy c%0d", k), 32'(busy_a), 32'h0);
      next_cycle();
    end
    run_basic("rerun", 1'b0);

    // Back-to-back passes, ready high on even cycles
    reset_dut();
    for (int k = 0; k <= 22; k++) begin
      logic ev;
      drive((k == 0) || (k == 8), col_at(k, 0, 0) | col_at(k, 8, 4), (k % 2) == 0);
      ev = (k >= 5 && k <= 20);
      check($sformatf("b2b valid c%0d", k), 32'(val_a), 32'(ev));
      check($sformatf("b2b row c%0d", k), row_a, ev ? row_val((k - 5) / 2) : 32'h0);
      check($sformatf("b2b busy c%0d", k), 32'(busy_a),
            32'((k >= 1 && k <= 7) || (k >= 9 && k <= 15)));
      check($sformatf("b2b ovf c%0d", k), 32'(ovf_a), 32'h0);
      next_cycle();
    end

    // Full FIFO: pushes of the second pass coincide with pops at count=4
    reset_dut();
    for (int k = 0; k <= 21; k++) begin
      logic [31:0] ea;
      drive((k == 0) || (k == 8), col_at(k, 0, 0) | col_at(k, 8, 4), k >= 12);
      ea = (k < 5) ? 32'h0 : (k <= 11) ? row_val(0) : (k <= 19) ? row_val(k - 12) : 32'h0;
      check($sformatf("full valid c%0d", k), 32'(val_a), 32'(k >= 5 && k <= 19));
      check($sformatf("full row c%0d", k), row_a, ea);
      check($sformatf("full ovf c%0d", k), 32'(ovf_a), 32'h0);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
